// File: rtl/instruction_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_issue_arbiter
//  Purpose  : Round-robin selection of one hazard-free thread head per cycle,
//             dequeue through is_thread_scheduled_mask, and a single-entry
//             issue stage feeding operand fetch, with rollback flush.
//  Options  : ISSUE_STATS_EN - per-thread issue counters on is_issue_count
//             THREAD_NUMB    - thread count (defaults to 8 when not provided)
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef THREAD_NUMB
`define THREAD_NUMB 8
`endif

module instruction_issue_arbiter #(
    parameter int RR_RESET_PTR = 0,
    parameter int STAT_WIDTH   = 32,
    parameter int INSTR_W      = 32,
    localparam int T           = `THREAD_NUMB,
    localparam int TW          = (T > 1) ? $clog2(T) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [T-1:0]            ib_instructions_valid,
    input  logic [T*INSTR_W-1:0]    ib_instructions,
    input  logic [T-1:0]            hazard_free_mask,
    input  logic [T-1:0]            rb_valid,
    input  logic                    downstream_ready,
    output logic [T-1:0]            is_thread_scheduled_mask,
    output logic                    is_instr_valid,
    output logic [INSTR_W-1:0]      is_instr,
    output logic [TW-1:0]           is_thread_id,
    output logic [T*STAT_WIDTH-1:0] is_issue_count
);

    logic [TW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [TW-1:0]      tid_q, tid_d;

    logic [T-1:0]       w_eligible;
    logic               w_can_load;
    logic               w_found;
    logic [TW-1:0]      w_winner;
    logic [INSTR_W-1:0] w_win_instr;
    logic               w_pop;
    logic               w_flush;

    assign w_eligible = ib_instructions_valid & hazard_free_mask & ~rb_valid;
    // Gated by reset so no dequeue is ever signalled while the block is held in reset.
    assign w_can_load = reset & enable & (~valid_q | downstream_ready);
    assign w_pop      = w_can_load & w_found;
    assign w_flush    = valid_q & rb_valid[tid_q];

    // Round-robin scan starting at rr_ptr with wrap-around; first eligible thread wins.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int i = 0; i < T; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= T) begin
                idx = idx - T;
            end
            if (!w_found && w_eligible[TW'(idx)]) begin
                w_found  = 1'b1;
                w_winner = TW'(idx);
            end
        end
    end

    // Select the winning thread's head instruction.
    always_comb begin
        w_win_instr = '0;
        for (int t = 0; t < T; t++) begin
            if (w_winner == TW'(t)) begin
                w_win_instr = ib_instructions[t*INSTR_W +: INSTR_W];
            end
        end
    end

    assign is_thread_scheduled_mask = w_pop ? (T'(1) << w_winner) : '0;

    // Issue-stage next state: a pop loads the stage (and covers any flush or consume of
    // the old entry); otherwise a flush or a downstream consume empties it.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        tid_d    = tid_q;
        if (w_pop) begin
            valid_d  = 1'b1;
            instr_d  = w_win_instr;
            tid_d    = w_winner;
            rr_ptr_d = (w_winner == TW'(T - 1)) ? '0 : w_winner + TW'(1);
        end else if (w_flush || (valid_q && downstream_ready)) begin
            valid_d = 1'b0;
        end
    end

    // Issue-stage and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= TW'(RR_RESET_PTR);
            valid_q  <= 1'b0;
            instr_q  <= '0;
            tid_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            tid_q    <= tid_d;
        end
    end

    assign is_instr_valid = valid_q;
    assign is_instr       = instr_q;
    assign is_thread_id   = tid_q;

`ifdef ISSUE_STATS_EN
    generate
        for (genvar t = 0; t < T; t++) begin : g_stat
            logic [STAT_WIDTH-1:0] cnt_q;
            // Count pops of this thread; wraps naturally and ignores rollback.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else if (w_pop && (w_winner == TW'(t))) begin
                    cnt_q <= cnt_q + STAT_WIDTH'(1);
                end
            end
            assign is_issue_count[t*STAT_WIDTH +: STAT_WIDTH] = cnt_q;
        end
    endgenerate
`else
    assign is_issue_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_issue_arbiter
//  Purpose  : Directed self-checking bench for instruction_issue_arbiter
//             (8 threads, 32-bit instructions).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_issue_arbiter;

    localparam int T  = 8;
    localparam int IW = 32;
    localparam int SW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [T-1:0]      ib_valid;
    logic [T*IW-1:0]   ib_instr;
    logic [T-1:0]      hz;
    logic [T-1:0]      rb;
    logic              ready;
    logic [T-1:0]      mask;
    logic              iv;
    logic [IW-1:0]     instr;
    logic [2:0]        tid;
    logic [T*SW-1:0]   cnt;

    int passed = 0;
    int total  = 0;

    instruction_issue_arbiter #(
        .RR_RESET_PTR(0),
        .STAT_WIDTH  (SW),
        .INSTR_W     (IW)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .ib_instructions_valid   (ib_valid),
        .ib_instructions         (ib_instr),
        .hazard_free_mask        (hz),
        .rb_valid                (rb),
        .downstream_ready        (ready),
        .is_thread_scheduled_mask(mask),
        .is_instr_valid          (iv),
        .is_instr                (instr),
        .is_thread_id            (tid),
        .is_issue_count          (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] instr_of(input int t);
        return 32'hC0DE_0000 + IW'(t);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_entry(input string tag, input int t);
        chk({tag, "_valid"}, 64'(iv), 64'd1);
        chk({tag, "_tid"}, 64'(tid), 64'(t));
        chk({tag, "_instr"}, 64'(instr), 64'(instr_of(t)));
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b1;
        ib_valid = 8'hFF;
        hz       = 8'hFF;
        rb       = 8'h00;
        ready    = 1'b1;
        for (int t = 0; t < T; t++) begin
            ib_instr[t*IW +: IW] = instr_of(t);
        end

        // Reset state: all eligible, but nothing popped while reset is low.
        #1;
        chk("rst_mask", 64'(mask), 64'h0);
        tick();
        chk("rst_valid", 64'(iv), 64'd0);
        chk("rst_tid", 64'(tid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_mask2", 64'(mask), 64'h0);
        reset = 1'b1;
        #1;

        // All eligible, ready: pops 0..7 then 0 again, back-to-back.
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("rr_mask%0d", k), 64'(mask), 64'(8'h01 << (k % 8)));
            tick();
            chk_entry($sformatf("rr_entry%0d", k), k % 8);
        end

        // Only thread 5 eligible; downstream stalls three cycles after its load.
        ib_valid = 8'h20;
        #1;
        chk("t5_mask", 64'(mask), 64'h20);
        tick();
        chk_entry("t5_load", 5);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold_mask%0d", k), 64'(mask), 64'h0);
            tick();
            chk_entry($sformatf("hold%0d", k), 5);
        end
        ready    = 1'b1;
        ib_valid = 8'h00;
        #1;
        chk("drain_mask", 64'(mask), 64'h0);
        tick();
        chk("drain_valid", 64'(iv), 64'd0);

        // rr_ptr now 6: eligible {6,0} -> 6 then 0 via wrap, pointer ends at 1.
        ib_valid = 8'h41;
        #1;
        chk("wrap_mask6", 64'(mask), 64'h40);
        tick();
        chk_entry("wrap6", 6);
        #1;
        chk("wrap_mask0", 64'(mask), 64'h01);
        tick();
        chk_entry("wrap0", 0);
        ib_valid = 8'hFF;
        #1;
        chk("ptr1_mask", 64'(mask), 64'h02);
        tick();
        chk_entry("ptr1", 1);

        // Rollback: load thread 2, then flush it with ready high.
        ib_valid = 8'h04;
        #1;
        chk("rb_load_mask", 64'(mask), 64'h04);
        tick();
        chk_entry("rb_load", 2);
        rb = 8'h04;
        #1;
        chk("rb_mask", 64'(mask), 64'h0);
        tick();
        chk("rb_flush_valid", 64'(iv), 64'd0);
        // Reload thread 2 (rr_ptr=3 wraps round to 2), then flush while thread 3 wins.
        rb = 8'h00;
        #1;
        chk("rb_reload_mask", 64'(mask), 64'h04);
        tick();
        chk_entry("rb_reload", 2);
        rb       = 8'h04;
        ib_valid = 8'h0C;
        #1;
        chk("rb_t3_mask", 64'(mask), 64'h08);
        tick();
        chk_entry("rb_t3", 3);
        rb = 8'h00;

        // enable=0: entry drains, no pops, pointer frozen at 4.
        enable   = 1'b0;
        ib_valid = 8'hFF;
        #1;
        chk("en0_mask", 64'(mask), 64'h0);
        tick();
        chk("en0_valid", 64'(iv), 64'd0);
        chk("en0_mask2", 64'(mask), 64'h0);
        tick();
        chk("en0_valid2", 64'(iv), 64'd0);
        enable = 1'b1;
        #1;
        chk("en1_mask", 64'(mask), 64'h10);
        tick();
        chk_entry("en1", 4);

        // Asynchronous reset mid-burst clears outputs immediately.
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(iv), 64'd0);
        chk("arst_tid", 64'(tid), 64'd0);
        chk("arst_instr", 64'(instr), 64'd0);
        chk("arst_mask", 64'(mask), 64'h0);
        chk("arst_cnt", 64'(cnt[4*SW +: SW]), 64'd0);
        tick();
        reset    = 1'b1;
        ib_valid = 8'h02;
        #1;
        chk("post_rst_mask", 64'(mask), 64'h02);
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        chk_entry("burst_t1", 1);
`ifdef ISSUE_STATS_EN
        chk("cnt1", 64'(cnt[1*SW +: SW]), 64'd10);
`else
        chk("cnt1", 64'(cnt[1*SW +: SW]), 64'd0);
`endif
        chk("cnt0", 64'(cnt[0 +: SW]), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
